// File: rtl/sm_reader_pkg.sv
// ----------------------------------------------------------------------------
// sm : shared-memory common types
//
// Holds the cell pointer width, command encoding, the cell-memory word layout
// and the reader FSM state encoding. Imported by the reader interface and the
// reader engine.
//
// Contents:
//   SM_PTR_WIDTH / sm_ptr_t   cell pointer width and type
//   SM_DATA_WIDTH             payload bits per cell (layout of sm_cell_t)
//   sm_cmd_code_t / sm_cmd_t  reader command {code, head ptr}
//   sm_cell_t                 cell memory word {next_ptr, eop, data}
//   sm_rd_state_t             reader FSM states
//   sm_hop_at_limit()         loop-guard helper
// ----------------------------------------------------------------------------
package sm;

    localparam int SM_PTR_WIDTH  = 8;
    localparam int SM_DATA_WIDTH = 32;

    typedef logic [SM_PTR_WIDTH-1:0] sm_ptr_t;

    typedef enum logic [0:0] {
        RD    = 1'b0,
        CLEAR = 1'b1
    } sm_cmd_code_t;

    typedef struct packed {
        sm_cmd_code_t code;
        sm_ptr_t      ptr;
    } sm_cmd_t;

    typedef struct packed {
        sm_ptr_t                  next_ptr;
        logic                     eop;
        logic [SM_DATA_WIDTH-1:0] data;
    } sm_cell_t;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_WAIT  = 3'd2,
        ST_OUT   = 3'd3,
        ST_FREE  = 3'd4
    } sm_rd_state_t;

    // True when the hop counter has reached one full pass over the pointer
    // space: a chain can never legitimately be longer than that.
    function automatic logic sm_hop_at_limit(input logic [SM_PTR_WIDTH:0] hop);
        return hop == {1'b1, {SM_PTR_WIDTH{1'b0}}};
    endfunction

endpackage

// File: rtl/sm_reader_if.sv
// ----------------------------------------------------------------------------
// sm_reader_if : bus bundle of the shared-memory reader
//
// Groups the command, cell-memory read, packet-out and free-list handshakes.
// Signal suffixes are from the reader's point of view.
//
// Modports:
//   master : the reader engine (drives *_o, samples *_i)
//   slave  : the surrounding system (command source, cell memory, packet
//            sink and allocator)
// ----------------------------------------------------------------------------
interface sm_reader_if #(
    parameter int DATA_WIDTH = 32
) ();

    // command channel
    sm::sm_cmd_t                                cmd_i;
    logic                                       cmd_valid_i;
    logic                                       cmd_ready_o;
    // cell memory read port, data returns exactly one cycle after the strobe
    logic                                       mem_rd_en_o;
    sm::sm_ptr_t                                mem_rd_addr_o;
    logic [DATA_WIDTH+sm::SM_PTR_WIDTH:0]       mem_rd_data_i;
    // packet word stream
    logic [DATA_WIDTH-1:0]                      rd_data_o;
    logic                                       rd_sop_o;
    logic                                       rd_eop_o;
    logic                                       rd_valid_o;
    logic                                       rd_ready_i;
    // cell release towards the allocator
    sm::sm_ptr_t                                free_ptr_o;
    logic                                       free_valid_o;
    logic                                       free_ready_i;

    modport master (
        input  cmd_i, cmd_valid_i, mem_rd_data_i, rd_ready_i, free_ready_i,
        output cmd_ready_o, mem_rd_en_o, mem_rd_addr_o,
               rd_data_o, rd_sop_o, rd_eop_o, rd_valid_o,
               free_ptr_o, free_valid_o
    );

    modport slave (
        output cmd_i, cmd_valid_i, mem_rd_data_i, rd_ready_i, free_ready_i,
        input  cmd_ready_o, mem_rd_en_o, mem_rd_addr_o,
               rd_data_o, rd_sop_o, rd_eop_o, rd_valid_o,
               free_ptr_o, free_valid_o
    );

endinterface

// File: rtl/sm_reader.sv
// ----------------------------------------------------------------------------
// sm_reader : read/release engine of the shared-memory block
//
// Accepts one command at a time (RD or CLEAR with a head pointer) and walks the
// packet's linked cell chain. RD streams each cell's payload as a packet word;
// CLEAR hands every cell pointer back to the allocator. One cell takes three
// cycles (FETCH, WAIT, OUT/FREE) when the consumer is always ready.
//
// Ports:
//   clk_i       clock
//   rst_n_i     asynchronous active-low reset
//   bus         sm_reader_if.master: cmd / mem read / rd stream / free
//   err_loop_o  one-cycle pulse: chain longer than 2^SM_PTR_WIDTH cells
//   busy_o      engine is not idle
//
// Build option:
//   SM_READER_AUTO_FREE_EN  when defined, RD also releases each cell right
//                           after its word has been accepted downstream.
// ----------------------------------------------------------------------------
module sm_reader #(
    parameter int DATA_WIDTH = 32
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    sm_reader_if.master   bus,
    output logic          err_loop_o,
    output logic          busy_o
);
    import sm::*;

    // state and walk context
    sm_rd_state_t            state_q;
    sm_cmd_code_t            code_q;
    sm_ptr_t                 cur_ptr_q;
    sm_ptr_t                 next_ptr_q;
    logic                    eop_q;
    logic                    first_q;
    logic [SM_PTR_WIDTH:0]   hop_cnt_q;

    // registered outputs
    logic                    cmd_ready_q;
    logic                    mem_rd_en_q;
    sm_ptr_t                 mem_rd_addr_q;
    logic [DATA_WIDTH-1:0]   rd_data_q;
    logic                    rd_sop_q;
    logic                    rd_eop_q;
    logic                    rd_valid_q;
    sm_ptr_t                 free_ptr_q;
    logic                    free_valid_q;
    logic                    err_loop_q;
    logic                    busy_q;

    // unpacked view of the returning cell word
    logic [DATA_WIDTH-1:0]   cell_data_d;
    logic                    cell_eop_d;
    sm_ptr_t                 cell_next_d;
    logic                    hop_limit_d;
    logic                    eop_eff_d;
    logic                    loop_err_d;

    assign cell_data_d = bus.mem_rd_data_i[DATA_WIDTH-1:0];
    assign cell_eop_d  = bus.mem_rd_data_i[DATA_WIDTH];
    assign cell_next_d = bus.mem_rd_data_i[DATA_WIDTH+SM_PTR_WIDTH:DATA_WIDTH+1];

    // A cell fetched on the last permitted hop closes the packet even without
    // eop, so a corrupted (looping) chain still terminates.
    assign hop_limit_d = sm_hop_at_limit(hop_cnt_q);
    assign eop_eff_d   = cell_eop_d | hop_limit_d;
    assign loop_err_d  = hop_limit_d & ~cell_eop_d;

    // Reader FSM with all outputs registered on the state transitions
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q       <= ST_IDLE;
            code_q        <= RD;
            cur_ptr_q     <= '0;
            next_ptr_q    <= '0;
            eop_q         <= 1'b0;
            first_q       <= 1'b0;
            hop_cnt_q     <= '0;
            cmd_ready_q   <= 1'b1;
            mem_rd_en_q   <= 1'b0;
            mem_rd_addr_q <= '0;
            rd_data_q     <= '0;
            rd_sop_q      <= 1'b0;
            rd_eop_q      <= 1'b0;
            rd_valid_q    <= 1'b0;
            free_ptr_q    <= '0;
            free_valid_q  <= 1'b0;
            err_loop_q    <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            err_loop_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (bus.cmd_valid_i) begin
                        code_q        <= bus.cmd_i.code;
                        cur_ptr_q     <= bus.cmd_i.ptr;
                        hop_cnt_q     <= '0;
                        first_q       <= 1'b1;
                        cmd_ready_q   <= 1'b0;
                        busy_q        <= 1'b1;
                        mem_rd_en_q   <= 1'b1;
                        mem_rd_addr_q <= bus.cmd_i.ptr;
                        state_q       <= ST_FETCH;
                    end else begin
                        cmd_ready_q <= 1'b1;
                        busy_q      <= 1'b0;
                    end
                end

                ST_FETCH: begin
                    mem_rd_en_q <= 1'b0;
                    hop_cnt_q   <= hop_cnt_q + (SM_PTR_WIDTH+1)'(1);
                    state_q     <= ST_WAIT;
                end

                ST_WAIT: begin
                    next_ptr_q <= cell_next_d;
                    eop_q      <= eop_eff_d;
                    err_loop_q <= loop_err_d;
                    if (code_q == RD) begin
                        rd_valid_q <= 1'b1;
                        rd_data_q  <= cell_data_d;
                        rd_sop_q   <= first_q;
                        rd_eop_q   <= eop_eff_d;
                        state_q    <= ST_OUT;
                    end else begin
                        free_valid_q <= 1'b1;
                        free_ptr_q   <= cur_ptr_q;
                        state_q      <= ST_FREE;
                    end
                end

                ST_OUT: begin
                    if (bus.rd_ready_i) begin
                        rd_valid_q <= 1'b0;
                        rd_sop_q   <= 1'b0;
                        rd_eop_q   <= 1'b0;
                        first_q    <= 1'b0;
`ifdef SM_READER_AUTO_FREE_EN
                        // the consumed cell is released before moving on
                        free_valid_q <= 1'b1;
                        free_ptr_q   <= cur_ptr_q;
                        state_q      <= ST_FREE;
`else
                        if (eop_q) begin
                            cmd_ready_q <= 1'b1;
                            busy_q      <= 1'b0;
                            state_q     <= ST_IDLE;
                        end else begin
                            cur_ptr_q     <= next_ptr_q;
                            mem_rd_en_q   <= 1'b1;
                            mem_rd_addr_q <= next_ptr_q;
                            state_q       <= ST_FETCH;
                        end
`endif
                    end
                end

                ST_FREE: begin
                    if (bus.free_ready_i) begin
                        free_valid_q <= 1'b0;
                        if (eop_q) begin
                            cmd_ready_q <= 1'b1;
                            busy_q      <= 1'b0;
                            state_q     <= ST_IDLE;
                        end else begin
                            cur_ptr_q     <= next_ptr_q;
                            mem_rd_en_q   <= 1'b1;
                            mem_rd_addr_q <= next_ptr_q;
                            state_q       <= ST_FETCH;
                        end
                    end
                end

                default: begin
                    cmd_ready_q  <= 1'b1;
                    busy_q       <= 1'b0;
                    mem_rd_en_q  <= 1'b0;
                    rd_valid_q   <= 1'b0;
                    free_valid_q <= 1'b0;
                    state_q      <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.cmd_ready_o   = cmd_ready_q;
    assign bus.mem_rd_en_o   = mem_rd_en_q;
    assign bus.mem_rd_addr_o = mem_rd_addr_q;
    assign bus.rd_data_o     = rd_data_q;
    assign bus.rd_sop_o      = rd_sop_q;
    assign bus.rd_eop_o      = rd_eop_q;
    assign bus.rd_valid_o    = rd_valid_q;
    assign bus.free_ptr_o    = free_ptr_q;
    assign bus.free_valid_o  = free_valid_q;
    assign err_loop_o        = err_loop_q;
    assign busy_o            = busy_q;

endmodule

// File: tb/tb_sm_reader.sv
// ----------------------------------------------------------------------------
// tb_sm_reader : directed self-checking bench for sm_reader
//
// A behavioural cell memory answers one cycle after each read strobe. Inputs
// change 1 ns after the rising edge, outputs are sampled on the falling edge.
// ----------------------------------------------------------------------------
module tb_sm_reader;
    import sm::*;

    logic clk;
    logic rst_n;
    logic err_loop;
    logic busy;

    sm_reader_if #(.DATA_WIDTH(32)) bus ();

    sm_reader #(.DATA_WIDTH(32)) dut (
        .clk_i      (clk),
        .rst_n_i    (rst_n),
        .bus        (bus),
        .err_loop_o (err_loop),
        .busy_o     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // cell memory model: registered read, one-cycle latency
    sm_cell_t mem [256];
    always @(posedge clk) begin
        if (bus.mem_rd_en_o) bus.mem_rd_data_i <= mem[bus.mem_rd_addr_o];
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    endtask

    // results of the last collect() run
    logic [31:0] w_data [$];
    logic        w_sop  [$];
    logic        w_eop  [$];
    logic [7:0]  f_ptr  [$];
    logic [40:0] ev     [$];
    int first_w_cyc, first_f_cyc, err_cnt, err_at, done_cyc, last_hs;
    bit done;
    logic rdy_at_done;

    task automatic issue_cmd(input sm_cmd_code_t c, input logic [7:0] p);
        @(posedge clk); #1;
        bus.cmd_i       = '{code: c, ptr: p};
        bus.cmd_valid_i = 1'b1;
        @(posedge clk); #1;
        bus.cmd_valid_i = 1'b0;
    endtask

    // Record every handshake until the engine goes idle; cycle 0 is T+1.
    task automatic collect(input int max_cyc);
        w_data.delete(); w_sop.delete(); w_eop.delete(); f_ptr.delete(); ev.delete();
        first_w_cyc = -1; first_f_cyc = -1; err_cnt = 0; err_at = -1;
        done_cyc = -1; last_hs = -1; done = 1'b0; rdy_at_done = 1'b0;
        for (int c = 0; c < max_cyc; c++) begin
            @(negedge clk);
            if (!busy) begin
                done = 1'b1; done_cyc = c; rdy_at_done = bus.cmd_ready_o;
                break;
            end
            if (err_loop) begin err_cnt++; err_at = f_ptr.size(); end
            if (bus.rd_valid_o && bus.rd_ready_i) begin
                if (first_w_cyc < 0) first_w_cyc = c;
                w_data.push_back(bus.rd_data_o);
                w_sop.push_back(bus.rd_sop_o);
                w_eop.push_back(bus.rd_eop_o);
                ev.push_back({1'b0, bus.rd_data_o});
                last_hs = c;
            end
            if (bus.free_valid_o && bus.free_ready_i) begin
                if (first_f_cyc < 0) first_f_cyc = c;
                f_ptr.push_back(bus.free_ptr_o);
                ev.push_back({1'b1, 24'h0, bus.free_ptr_o});
                last_hs = c;
            end
        end
        check("walk_done", 64'(done), 64'd1);
        check("zero_bubble_gap", 64'(done_cyc - last_hs), 64'd1);
        check("zero_bubble_ready", 64'(rdy_at_done), 64'd1);
    endtask

    task automatic run_rd_abc();
        logic [31:0] exp_d [3];
        logic        exp_s [3];
        logic        exp_e [3];
        exp_d = '{32'hA, 32'hB, 32'hC};
        exp_s = '{1'b1, 1'b0, 1'b0};
        exp_e = '{1'b0, 1'b0, 1'b1};
        issue_cmd(RD, 8'h05);
        collect(60);
        check("rd_first_latency", 64'(first_w_cyc), 64'd2);
        check("rd_word_count", 64'(w_data.size()), 64'd3);
        for (int i = 0; i < 3; i++) begin
            check("rd_data", 64'(i < w_data.size() ? w_data[i] : 32'hDEAD), 64'(exp_d[i]));
            check("rd_sop",  64'(i < w_sop.size()  ? w_sop[i]  : 1'bx),     64'(exp_s[i]));
            check("rd_eop",  64'(i < w_eop.size()  ? w_eop[i]  : 1'bx),     64'(exp_e[i]));
        end
`ifndef SM_READER_AUTO_FREE_EN
        check("rd_no_free", 64'(f_ptr.size()), 64'd0);
`endif
    endtask

    task automatic wait_idle(input int max_cyc);
        bit idle;
        idle = 1'b0;
        for (int c = 0; c < max_cyc; c++) begin
            @(negedge clk);
            if (!busy) begin idle = 1'b1; break; end
        end
        check("wait_idle", 64'(idle), 64'd1);
    endtask

    initial begin
        logic [7:0] exp_p [3];
        logic [7:0] held_ptr;
        bit held_pending, rd_seen, clr_done;
        int bad_ptr;

        bus.cmd_i         = '{code: RD, ptr: 8'h00};
        bus.cmd_valid_i   = 1'b0;
        bus.rd_ready_i    = 1'b1;
        bus.free_ready_i  = 1'b1;
        bus.mem_rd_data_i = '0;
        for (int i = 0; i < 256; i++) mem[i] = '0;
        mem[8'h05] = '{next_ptr: 8'h09, eop: 1'b0, data: 32'h0000_000A};
        mem[8'h09] = '{next_ptr: 8'h02, eop: 1'b0, data: 32'h0000_000B};
        mem[8'h02] = '{next_ptr: 8'hEE, eop: 1'b1, data: 32'h0000_000C};
        mem[8'h10] = '{next_ptr: 8'h33, eop: 1'b1, data: 32'h0000_1234};
        mem[8'h07] = '{next_ptr: 8'h07, eop: 1'b0, data: 32'h0000_0077};
        mem[8'h20] = '{next_ptr: 8'h21, eop: 1'b0, data: 32'h0000_000D};
        mem[8'h21] = '{next_ptr: 8'h00, eop: 1'b1, data: 32'h0000_000E};

        // reset values
        rst_n = 1'b0;
        #13;
        check("reset_outputs",
              64'({bus.cmd_ready_o, bus.mem_rd_en_o, bus.rd_valid_o, bus.rd_sop_o,
                   bus.rd_eop_o, bus.free_valid_o, err_loop, busy}),
              64'b1000_0000);
        @(negedge clk); rst_n = 1'b1;

        // three-cell RD with ready held high
        run_rd_abc();

        // CLEAR with the allocator toggling ready: pointers held while stalled
        exp_p = '{8'h05, 8'h09, 8'h02};
        bus.free_ready_i = 1'b0;
        issue_cmd(CLEAR, 8'h05);
        f_ptr.delete();
        held_pending = 1'b0; rd_seen = 1'b0; clr_done = 1'b0; first_f_cyc = -1;
        held_ptr = '0;
        for (int c = 0; c < 40; c++) begin
            bus.free_ready_i = (c % 2 == 1);
            @(negedge clk);
            if (held_pending) begin
                check("clr_hold_valid", 64'(bus.free_valid_o), 64'd1);
                check("clr_hold_ptr", 64'(bus.free_ptr_o), 64'(held_ptr));
                held_pending = 1'b0;
            end
            if (bus.rd_valid_o) rd_seen = 1'b1;
            if (bus.free_valid_o) begin
                if (first_f_cyc < 0) first_f_cyc = c;
                if (bus.free_ready_i) f_ptr.push_back(bus.free_ptr_o);
                else begin held_pending = 1'b1; held_ptr = bus.free_ptr_o; end
            end
            if (!busy && f_ptr.size() > 0) begin clr_done = 1'b1; break; end
            @(posedge clk); #1;
        end
        check("clr_done", 64'(clr_done), 64'd1);
        check("clr_first_latency", 64'(first_f_cyc), 64'd2);
        check("clr_free_count", 64'(f_ptr.size()), 64'd3);
        for (int i = 0; i < 3; i++)
            check("clr_free_ptr", 64'(i < f_ptr.size() ? f_ptr[i] : 8'hxx), 64'(exp_p[i]));
        check("clr_no_rd", 64'(rd_seen), 64'd0);
        bus.free_ready_i = 1'b1;

        // single-cell RD, consumer stalls 4 cycles
        @(posedge clk); #1;
        bus.rd_ready_i = 1'b0;
        issue_cmd(RD, 8'h10);
        @(negedge clk);
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("single_stall_word",
                  64'({bus.rd_valid_o, bus.rd_sop_o, bus.rd_eop_o, bus.rd_data_o}),
                  64'({1'b1, 1'b1, 1'b1, 32'h0000_1234}));
        end
        @(posedge clk); #1;
        bus.rd_ready_i = 1'b1;
        @(negedge clk);
        check("single_hs_valid", 64'(bus.rd_valid_o), 64'd1);
        @(negedge clk);
`ifndef SM_READER_AUTO_FREE_EN
        check("single_ready_after", 64'(bus.cmd_ready_o), 64'd1);
`else
        check("single_autofree", 64'({bus.free_valid_o, bus.free_ptr_o}), 64'({1'b1, 8'h10}));
`endif
        wait_idle(20);

        // self-looping chain: loop guard ends the walk after 256 cells
        issue_cmd(CLEAR, 8'h07);
        collect(1000);
        bad_ptr = 0;
        foreach (f_ptr[i]) if (f_ptr[i] != 8'h07) bad_ptr++;
        check("loop_free_count", 64'(f_ptr.size()), 64'd256);
        check("loop_free_ptr_bad", 64'(bad_ptr), 64'd0);
        check("loop_err_pulses", 64'(err_cnt), 64'd1);
        check("loop_err_position", 64'(err_at), 64'd255);

        // asynchronous reset in the middle of a three-cell RD
        @(posedge clk); #1;
        bus.rd_ready_i = 1'b0;
        issue_cmd(RD, 8'h05);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        check("rst_pre_valid", 64'(bus.rd_valid_o), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_async_outputs",
              64'({bus.cmd_ready_o, bus.mem_rd_en_o, bus.rd_valid_o, bus.rd_sop_o,
                   bus.rd_eop_o, bus.rd_data_o, bus.free_valid_o, err_loop, busy}),
              64'({1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0}));
        @(negedge clk);
        rst_n = 1'b1;
        bus.rd_ready_i = 1'b1;
        @(negedge clk);
        check("rst_idle_after", 64'({bus.cmd_ready_o, busy}), 64'b10);
        run_rd_abc();

`ifdef SM_READER_AUTO_FREE_EN
        // read-and-release ordering
        issue_cmd(RD, 8'h20);
        collect(60);
        check("auto_event_count", 64'(ev.size()), 64'd4);
        check("auto_ev0", 64'(ev.size() > 0 ? ev[0] : 41'h0), 64'({1'b0, 32'h0000_000D}));
        check("auto_ev1", 64'(ev.size() > 1 ? ev[1] : 41'h0), 64'({1'b1, 24'h0, 8'h20}));
        check("auto_ev2", 64'(ev.size() > 2 ? ev[2] : 41'h0), 64'({1'b0, 32'h0000_000E}));
        check("auto_ev3", 64'(ev.size() > 3 ? ev[3] : 41'h0), 64'({1'b1, 24'h0, 8'h21}));
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
